// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Brief    : DES key-schedule tables, widths and bit-manipulation helpers.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int c_KEY_W    = 64;
    localparam int c_CD_W     = 56;
    localparam int c_HALF_W   = 28;
    localparam int c_SUBKEY_W = 48;

    // 1-based DES bit numbers: entry n-1 names the source bit of output bit n
    localparam int c_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int c_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit k-1 set means round k shifts by two
    localparam logic [15:0] c_SHIFT2_MASK = 16'h7EFC;

    function automatic logic [c_HALF_W-1:0] rotl28(input logic [c_HALF_W-1:0] x,
                                                   input logic by2);
        return by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [c_HALF_W-1:0] rotr28(input logic [c_HALF_W-1:0] x,
                                                   input logic by2);
        return by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // DES bit n lives at key[64-n]; output is assembled MSB (bit 1) first
    function automatic logic [c_CD_W-1:0] pc1(input logic [c_KEY_W-1:0] k);
        logic [c_CD_W-1:0]  r;
        logic [c_KEY_W-1:0] t;
        r = '0;
        for (int i = 0; i < c_CD_W; i++) begin
            t = k >> (c_KEY_W - c_PC1[i]);
            r = {r[c_CD_W-2:0], t[0]};
        end
        return r;
    endfunction

    function automatic logic parity_fail(input logic [c_KEY_W-1:0] k);
        logic [7:0] b;
        logic       bad;
        bad = 1'b0;
        for (int j = 0; j < 8; j++) begin
            b = 8'(k >> (8 * j));
            if (^b == 1'b0) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module   : des_pc2
// Brief    : Combinational PC-2 compression of the 56-bit CD register.
// Revision : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [c_CD_W-1:0]     i_cd,
    output logic [c_SUBKEY_W-1:0] o_subkey
);

    for (genvar i = 0; i < c_SUBKEY_W; i++) begin : g_bit
        assign o_subkey[c_SUBKEY_W-1-i] = i_cd[c_CD_W - c_PC2[i]];
    end

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Brief    : Streams the sixteen DES round subkeys, forward or reversed.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
#(
    parameter int PARITY_CHECK = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [c_KEY_W-1:0]    key_in,
    input  logic                  decrypt,
    input  logic                  key_valid,
    output logic                  key_ready,
    output logic [c_SUBKEY_W-1:0] subkey_out,
    output logic [3:0]            subkey_idx,
    output logic                  subkey_last,
    output logic                  subkey_valid,
    input  logic                  subkey_ready,
    output logic                  key_parity_err,
    output logic                  busy
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_GEN  = 1'b1;

    logic [0:0]        r_state;
    logic [c_CD_W-1:0] r_cd;
    logic [3:0]        r_idx;
    logic              r_mode;
    logic              r_parity_err;

    logic [c_CD_W-1:0] w_key_cd;
    logic [c_CD_W-1:0] w_key_cd_enc;
    logic [c_CD_W-1:0] w_cd_next;
    logic              w_enc_by2;
    logic              w_dec_by2;
    logic              w_parity_bad;

    always_comb begin
        w_key_cd     = pc1(key_in);
        w_key_cd_enc = {rotl28(w_key_cd[55:28], 1'b0), rotl28(w_key_cd[27:0], 1'b0)};
        // Encrypt steps to round idx+2, decrypt steps back from round 16-idx
        w_enc_by2    = c_SHIFT2_MASK[r_idx + 4'd1];
        w_dec_by2    = c_SHIFT2_MASK[4'd15 - r_idx];
        if (r_mode)
            w_cd_next = {rotr28(r_cd[55:28], w_dec_by2), rotr28(r_cd[27:0], w_dec_by2)};
        else
            w_cd_next = {rotl28(r_cd[55:28], w_enc_by2), rotl28(r_cd[27:0], w_enc_by2)};
        w_parity_bad = (PARITY_CHECK != 0) ? parity_fail(key_in) : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cd         <= '0;
            r_idx        <= 4'd0;
            r_mode       <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (key_valid) begin
                        r_cd         <= decrypt ? w_key_cd : w_key_cd_enc;
                        r_mode       <= decrypt;
                        r_idx        <= 4'd0;
                        r_parity_err <= w_parity_bad;
                        r_state      <= c_ST_GEN;
                    end
                end
                c_ST_GEN: begin
                    if (subkey_ready) begin
                        if (r_idx == 4'd15) begin
                            r_idx   <= 4'd0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cd  <= w_cd_next;
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .i_cd     (r_cd),
        .o_subkey (subkey_out)
    );

    assign key_ready      = (r_state == c_ST_IDLE);
    assign subkey_valid   = (r_state == c_ST_GEN);
    assign busy           = (r_state == c_ST_GEN);
    assign subkey_idx     = r_idx;
    assign subkey_last    = (r_idx == 4'd15);
    assign key_parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Brief    : Directed-vector bench for des_key_schedule with parity checking on.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    localparam logic [63:0] c_KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] c_KEY_BAD  = 64'h133457799BBCDFF0;

    localparam logic [47:0] c_KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk;
    logic        rst;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey_out;
    logic [3:0]  subkey_idx;
    logic        subkey_last;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        key_parity_err;
    logic        busy;

    int checks;
    int errors;

    des_key_schedule #(.PARITY_CHECK(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .decrypt        (decrypt),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .subkey_out     (subkey_out),
        .subkey_idx     (subkey_idx),
        .subkey_last    (subkey_last),
        .subkey_valid   (subkey_valid),
        .subkey_ready   (subkey_ready),
        .key_parity_err (key_parity_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b0 ||
            subkey_out !== 48'h0 || subkey_idx !== 4'd0 || subkey_last !== 1'b0 ||
            key_parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset got rdy=%b v=%b busy=%b k=%h idx=%0d last=%b perr=%b exp 1 0 0 0 0 0 0",
                     key_ready, subkey_valid, busy, subkey_out, subkey_idx, subkey_last, key_parity_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_encrypt();
        key_in = c_KEY_GOOD; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL enc_key_ready got %b exp 1", key_ready);
        end
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (subkey_valid !== 1'b1 || busy !== 1'b1 || subkey_out !== c_KS[i] ||
                subkey_idx !== 4'(i) || subkey_last !== (i == 15) || key_parity_err !== 1'b0) begin
                errors++;
                $display("FAIL enc_k%0d got v=%b k=%h idx=%0d last=%b perr=%b exp v=1 k=%h idx=%0d last=%b perr=0",
                         i, subkey_valid, subkey_out, subkey_idx, subkey_last, key_parity_err,
                         c_KS[i], i, (i == 15));
            end
            tick();
        end
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL enc_idle got rdy=%b v=%b busy=%b exp 1 0 0", key_ready, subkey_valid, busy);
        end
    endtask

    task automatic test_decrypt();
        key_in = c_KEY_GOOD; decrypt = 1'b1; key_valid = 1'b1; subkey_ready = 1'b1;
        tick();
        key_valid = 1'b0; decrypt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (subkey_valid !== 1'b1 || subkey_out !== c_KS[15-i] ||
                subkey_idx !== 4'(i) || subkey_last !== (i == 15)) begin
                errors++;
                $display("FAIL dec_k%0d got v=%b k=%h idx=%0d last=%b exp v=1 k=%h idx=%0d last=%b",
                         i, subkey_valid, subkey_out, subkey_idx, subkey_last, c_KS[15-i], i, (i == 15));
            end
            tick();
        end
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
            errors++;
            $display("FAIL dec_idle got rdy=%b v=%b exp 1 0", key_ready, subkey_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] prev_k;
        logic [3:0]  prev_i;
        logic        rdy;
        logic        stalled;
        int          n;
        int          cyc;
        key_in = c_KEY_GOOD; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b0;
        tick();
        key_valid = 1'b0;
        n = 0; cyc = 0; stalled = 1'b0; prev_k = '0; prev_i = '0;
        while (n < 16 && cyc < 400) begin
            if (stalled) begin
                checks++;
                if (subkey_out !== prev_k || subkey_idx !== prev_i) begin
                    errors++;
                    $display("FAIL bp_stable got k=%h idx=%0d exp k=%h idx=%0d",
                             subkey_out, subkey_idx, prev_k, prev_i);
                end
            end
            checks++;
            if (subkey_valid !== 1'b1 || subkey_out !== c_KS[n] || subkey_idx !== 4'(n)) begin
                errors++;
                $display("FAIL bp_k%0d got v=%b k=%h idx=%0d exp v=1 k=%h idx=%0d",
                         n, subkey_valid, subkey_out, subkey_idx, c_KS[n], n);
            end
            prev_k = subkey_out;
            prev_i = subkey_idx;
            rdy = ($urandom_range(0, 99) < 30);
            subkey_ready = rdy;
            tick();
            cyc++;
            if (rdy) n++;
            stalled = !rdy;
        end
        checks++;
        if (n != 16 || key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got n=%0d rdy=%b v=%b exp n=16 rdy=1 v=0", n, key_ready, subkey_valid);
        end
        subkey_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        key_in = c_KEY_GOOD; decrypt = 1'b1; key_valid = 1'b1; subkey_ready = 1'b1;
        tick();
        key_valid = 1'b0; decrypt = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (subkey_idx !== 4'd7 || subkey_out !== c_KS[8]) begin
            errors++;
            $display("FAIL mid_pre got idx=%0d k=%h exp idx=7 k=%h", subkey_idx, subkey_out, c_KS[8]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b0 ||
            subkey_out !== 48'h0 || subkey_idx !== 4'd0 || subkey_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_rst got rdy=%b v=%b busy=%b k=%h idx=%0d last=%b exp 1 0 0 0 0 0",
                     key_ready, subkey_valid, busy, subkey_out, subkey_idx, subkey_last);
        end
        tick();
        rst = 1'b0;
        tick();
        key_in = c_KEY_GOOD; decrypt = 1'b0; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (subkey_valid !== 1'b1 || subkey_out !== c_KS[i] || subkey_idx !== 4'(i)) begin
                errors++;
                $display("FAIL mid_k%0d got v=%b k=%h idx=%0d exp v=1 k=%h idx=%0d",
                         i, subkey_valid, subkey_out, subkey_idx, c_KS[i], i);
            end
            tick();
        end
    endtask

    task automatic test_parity();
        key_in = c_KEY_BAD; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (key_parity_err !== 1'b1 || subkey_out !== c_KS[i] || subkey_idx !== 4'(i)) begin
                errors++;
                $display("FAIL par_k%0d got perr=%b k=%h idx=%0d exp perr=1 k=%h idx=%0d",
                         i, key_parity_err, subkey_out, subkey_idx, c_KS[i], i);
            end
            tick();
        end
        key_in = c_KEY_GOOD; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        checks++;
        if (key_parity_err !== 1'b0 || subkey_out !== c_KS[0]) begin
            errors++;
            $display("FAIL par_good got perr=%b k=%h exp perr=0 k=%h", key_parity_err, subkey_out, c_KS[0]);
        end
        for (int i = 0; i < 16; i++) tick();
    endtask

    task automatic test_key_while_busy();
        key_in = c_KEY_GOOD; decrypt = 1'b0; key_valid = 1'b1; subkey_ready = 1'b1;
        tick();
        // Second key (bad parity, decrypt) is offered continuously during the stream
        key_in = c_KEY_BAD; decrypt = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (key_ready !== 1'b0 || subkey_out !== c_KS[i] || key_parity_err !== 1'b0 ||
                subkey_idx !== 4'(i)) begin
                errors++;
                $display("FAIL busy_k%0d got rdy=%b k=%h perr=%b idx=%0d exp rdy=0 k=%h perr=0 idx=%0d",
                         i, key_ready, subkey_out, key_parity_err, subkey_idx, c_KS[i], i);
            end
            tick();
        end
        checks++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_gap got rdy=%b v=%b exp 1 0", key_ready, subkey_valid);
        end
        tick();
        key_valid = 1'b0; decrypt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (subkey_valid !== 1'b1 || subkey_out !== c_KS[15-i] || key_parity_err !== 1'b1 ||
                subkey_idx !== 4'(i) || subkey_last !== (i == 15)) begin
                errors++;
                $display("FAIL busy2_k%0d got v=%b k=%h perr=%b idx=%0d last=%b exp v=1 k=%h perr=1 idx=%0d",
                         i, subkey_valid, subkey_out, key_parity_err, subkey_idx, subkey_last, c_KS[15-i], i);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; key_in = '0; decrypt = 1'b0; key_valid = 1'b0; subkey_ready = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reset_midstream();
        test_parity();
        test_key_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
